// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: IF/MEM request ports and shared RAM port.
// slave = arbiter side, master = pipeline stages plus RAM macro.
interface unified_mem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 32
);
  logic                      if_req;
  logic [ADDRESS_WIDTH-1:0]  if_addr;
  logic                      if_done;
  logic [DATA_WIDTH-1:0]     if_rdata;
  logic                      if_stall;
  logic                      mem_req;
  logic                      mem_we;
  logic [ADDRESS_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH/8-1:0]   mem_be;
  logic                      mem_done;
  logic [DATA_WIDTH-1:0]     mem_rdata;
  logic                      mem_stall;
  logic                      ram_en;
  logic                      ram_we;
  logic [ADDRESS_WIDTH-1:0]  ram_addr;
  logic [DATA_WIDTH-1:0]     ram_wdata;
  logic [DATA_WIDTH/8-1:0]   ram_be;
  logic [DATA_WIDTH-1:0]     ram_rdata;

  modport slave (
    input  if_req, if_addr,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  ram_rdata,
    output if_done, if_rdata, if_stall,
    output mem_done, mem_rdata, mem_stall,
    output ram_en, ram_we, ram_addr, ram_wdata, ram_be
  );

  modport master (
    output if_req, if_addr,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output ram_rdata,
    input  if_done, if_rdata, if_stall,
    input  mem_done, mem_rdata, mem_stall,
    input  ram_en, ram_we, ram_addr, ram_wdata, ram_be
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: serialises IF and MEM onto one single-port RAM.
// Fetch starvation guard is built only with ARBITER_STARVATION_GUARD_EN.
module unified_mem_arbiter #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_LATENCY   = 1,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic clk,
  input  logic rst,
  unified_mem_arbiter_if.slave bus
);
  localparam int BW = DATA_WIDTH / 8;

  typedef enum logic [1:0] { S_IDLE, S_ISSUE, S_WAIT } state_t;
  typedef enum logic [1:0] { O_NONE, O_IF, O_MEM } owner_t;

  state_t                   state_q, state_d;
  owner_t                   owner_q, owner_d;
  logic [2:0]               cnt_q, cnt_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [BW-1:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0]    if_rdata_q, mem_rdata_q;
  logic                     grant_if, grant_mem, starved;
  logic                     done, if_done, mem_done;

`ifdef ARBITER_STARVATION_GUARD_EN
  logic [2:0] starve_q, starve_d;

  assign starved = (starve_q == 3'(STARVE_LIMIT));

  // Count back-to-back MEM grants that left a fetch waiting
  always_comb begin
    starve_d = starve_q;
    if (grant_if || (state_q == S_IDLE && !bus.if_req))
      starve_d = '0;
    else if (grant_mem && bus.if_req)
      starve_d = starve_q + 3'd1;
  end

  // Starvation counter register
  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  logic unused_starve;
  assign starved       = 1'b0;
  assign unused_starve = (STARVE_LIMIT != 0);
`endif

  // MEM wins in IDLE unless a waiting fetch has been starved
  always_comb begin
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    if (state_q == S_IDLE) begin
      if (bus.mem_req && !(starved && bus.if_req))
        grant_mem = 1'b1;
      else if (bus.if_req)
        grant_if = 1'b1;
    end
  end

  assign done     = (state_q == S_WAIT) && (cnt_q == '0);
  assign if_done  = done && (owner_q == O_IF);
  assign mem_done = done && (owner_q == O_MEM);

  // Next state: latch the winner, strobe once, count down the latency
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_mem) begin
          owner_d = O_MEM;
          we_d    = bus.mem_we;
          addr_d  = bus.mem_addr;
          wdata_d = bus.mem_wdata;
          be_d    = bus.mem_be;
          state_d = S_ISSUE;
        end else if (grant_if) begin
          owner_d = O_IF;
          we_d    = 1'b0;
          addr_d  = bus.if_addr;
          wdata_d = '0;
          be_d    = '1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 3'(MEM_LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          owner_d = O_NONE;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        owner_d = O_NONE;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, owner, counter and captured request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= O_NONE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  // Hold each stage's last read data between done pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      if (if_done)  if_rdata_q  <= bus.ram_rdata;
      if (mem_done) mem_rdata_q <= bus.ram_rdata;
    end
  end

  assign bus.ram_en    = (state_q == S_ISSUE);
  assign bus.ram_we    = (state_q == S_ISSUE) && we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.ram_be    = be_q;

  assign bus.if_done   = if_done;
  assign bus.mem_done  = mem_done;
  assign bus.if_rdata  = if_done  ? bus.ram_rdata : if_rdata_q;
  assign bus.mem_rdata = mem_done ? bus.ram_rdata : mem_rdata_q;
  assign bus.if_stall  = bus.if_req  && !if_done;
  assign bus.mem_stall = bus.mem_req && !mem_done;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: scoreboard bench, one DUT at latency 1
// and one at latency 4, each with its own RAM model.
module tb_unified_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) b1();
  unified_mem_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) b4();

  unified_mem_arbiter #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
    .MEM_LATENCY(1), .STARVE_LIMIT(4)
  ) u1 (.clk(clk), .rst(rst), .bus(b1));

  unified_mem_arbiter #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
    .MEM_LATENCY(4), .STARVE_LIMIT(4)
  ) u4 (.clk(clk), .rst(rst), .bus(b4));

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl1 [64];

  typedef struct {
    int          en_cnt;
    int          en_cyc;
    logic        we;
    logic [3:0]  be;
    logic [5:0]  addr;
    logic [31:0] wdata;
    int          done_cyc;
    logic [31:0] rdata;
    bit          ok;
  } obs_t;

  function automatic logic [31:0] init_val(input int i);
    if (i == 3) return 32'h0000_0013;
    return 32'hC0DE_0000 + 32'(i) * 32'h0000_0111;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++)
      if (be[k]) r[8*k +: 8] = w[8*k +: 8];
    return r;
  endfunction

  logic [31:0] ram1 [64];
  logic [31:0] p1;
  logic [31:0] p4 [4];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) ram1[i] <= init_val(i);
    end else if (b1.ram_en && b1.ram_we) begin
      for (int k = 0; k < 4; k++)
        if (b1.ram_be[k])
          ram1[b1.ram_addr][8*k +: 8] <= b1.ram_wdata[8*k +: 8];
    end
    p1 <= ram1[b1.ram_addr];
    p4[0] <= init_val(int'(b4.ram_addr));
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end

  assign b1.ram_rdata = p1;
  assign b4.ram_rdata = p4[3];

  a_if1: assert property (@(posedge clk) disable iff (rst)
    (b1.if_req && !b1.if_done) |=> b1.if_req)
    else $error("protocol: b1 if_req dropped before if_done");
  a_mem1: assert property (@(posedge clk) disable iff (rst)
    (b1.mem_req && !b1.mem_done) |=> b1.mem_req)
    else $error("protocol: b1 mem_req dropped before mem_done");
  a_if4: assert property (@(posedge clk) disable iff (rst)
    (b4.if_req && !b4.if_done) |=> b4.if_req)
    else $error("protocol: b4 if_req dropped before if_done");

  task automatic run_op(input bit is_if, input logic we,
                        input logic [5:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output obs_t o);
    o = '{default: 0};
    @(posedge clk); #1;
    if (is_if) begin
      b1.if_req = 1'b1; b1.if_addr = a;
    end else begin
      b1.mem_req = 1'b1; b1.mem_we = we; b1.mem_addr = a;
      b1.mem_wdata = wd; b1.mem_be = be;
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (b1.ram_en) begin
        o.en_cnt++; o.en_cyc = c; o.we = b1.ram_we; o.be = b1.ram_be;
        o.addr = b1.ram_addr; o.wdata = b1.ram_wdata;
      end
      if (is_if ? b1.if_done : b1.mem_done) begin
        o.done_cyc = c;
        o.rdata = is_if ? b1.if_rdata : b1.mem_rdata;
        o.ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    b1.if_req = 1'b0;
    b1.mem_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [109:0] v;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 64; i++) mdl1[i] = init_val(i);
    @(negedge clk);
    v = {b1.ram_en, b1.ram_we, b1.ram_addr, b1.ram_wdata, b1.ram_be,
         b1.if_done, b1.mem_done, b1.if_rdata, b1.mem_rdata};
    n_cmp++;
    if (v !== '0) begin
      n_bad++; $display("FAIL reset_u1: got %h want 0", v);
    end
    v = {b4.ram_en, b4.ram_we, b4.ram_addr, b4.ram_wdata, b4.ram_be,
         b4.if_done, b4.mem_done, b4.if_rdata, b4.mem_rdata};
    n_cmp++;
    if (v !== '0) begin
      n_bad++; $display("FAIL reset_u4: got %h want 0", v);
    end
    n_cmp++;
    if ({b1.if_stall, b1.mem_stall} !== 2'b00) begin
      n_bad++; $display("FAIL reset_stall: got %b want 00",
                        {b1.if_stall, b1.mem_stall});
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [109:0] v;
    int nd;
    @(posedge clk); #1;
    b4.if_req = 1'b1; b4.if_addr = 6'd5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (b4.ram_en !== (c == 1)) begin
        n_bad++; $display("FAIL midrst_en c%0d: got %b", c, b4.ram_en);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1; b4.if_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    v = {b4.ram_en, b4.ram_we, b4.ram_addr, b4.ram_wdata, b4.ram_be,
         b4.if_done, b4.mem_done, b4.if_rdata, b4.mem_rdata};
    n_cmp++;
    if (v !== '0 || b4.if_stall !== 1'b0) begin
      n_bad++; $display("FAIL midrst_zero: got %h stall %b want 0", v, b4.if_stall);
    end
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (b4.if_done) nd++;
    end
    n_cmp++;
    if (nd != 0) begin
      n_bad++; $display("FAIL midrst_nodone: got %0d pulses want 0", nd);
    end
    exp_q.push_back(init_val(5));
    @(posedge clk); #1;
    b4.if_req = 1'b1; b4.if_addr = 6'd5;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      n_cmp++;
      if (b4.if_done !== (c == 5)) begin
        n_bad++; $display("FAIL midrst_refetch c%0d: got %b", c, b4.if_done);
      end
      if (b4.if_done && exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        if (b4.if_rdata !== e) begin
          n_bad++; $display("FAIL midrst_data: got %h want %h", b4.if_rdata, e);
        end
      end
      @(posedge clk); #1;
      if (c == 5) b4.if_req = 1'b0;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL midrst_sb: %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_single_fetch();
    exp_q.push_back(32'h0000_0013);
    @(posedge clk); #1;
    b1.if_req = 1'b1; b1.if_addr = 6'd3;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp += 3;
      if (b1.ram_en !== (c == 1)) begin
        n_bad++; $display("FAIL fetch_en c%0d: got %b", c, b1.ram_en);
      end
      if (b1.if_done !== (c == 2)) begin
        n_bad++; $display("FAIL fetch_done c%0d: got %b", c, b1.if_done);
      end
      if (b1.if_stall !== (c < 2)) begin
        n_bad++; $display("FAIL fetch_stall c%0d: got %b", c, b1.if_stall);
      end
      if (c == 1) begin
        n_cmp++;
        if (b1.ram_addr !== 6'd3 || b1.ram_we !== 1'b0) begin
          n_bad++; $display("FAIL fetch_addr: got %0d we %b want 3 we 0",
                            b1.ram_addr, b1.ram_we);
        end
      end
      if (b1.if_done && exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        if (b1.if_rdata !== e) begin
          n_bad++; $display("FAIL fetch_data: got %h want %h", b1.if_rdata, e);
        end
      end
      @(posedge clk); #1;
      if (c == 2) b1.if_req = 1'b0;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL fetch_sb: %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_store_load();
    obs_t o;
    logic [31:0] e;
    run_op(1'b0, 1'b1, 6'd10, 32'hDEAD_BEEF, 4'hF, o);
    mdl1[10] = merge(mdl1[10], 32'hDEAD_BEEF, 4'hF);
    n_cmp++;
    if (!o.ok || o.done_cyc != 2 || o.en_cnt != 1 || o.en_cyc != 1) begin
      n_bad++; $display("FAIL store_timing: ok %0d done %0d en %0d@%0d want 1 2 1@1",
                        o.ok, o.done_cyc, o.en_cnt, o.en_cyc);
    end
    n_cmp++;
    if (o.we !== 1'b1 || o.be !== 4'hF || o.addr !== 6'd10 || o.wdata !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL store_issue: we %b be %h a %0d d %h want 1 f 10 deadbeef",
                        o.we, o.be, o.addr, o.wdata);
    end
    exp_q.push_back(mdl1[10]);
    run_op(1'b0, 1'b0, 6'd10, 32'h0, 4'hF, o);
    e = exp_q.pop_front();
    n_cmp++;
    if (!o.ok || o.rdata !== e || o.we !== 1'b0) begin
      n_bad++; $display("FAIL load_data: ok %0d got %h we %b want %h we 0",
                        o.ok, o.rdata, o.we, e);
    end
    run_op(1'b0, 1'b1, 6'd11, 32'h1122_3344, 4'b0101, o);
    mdl1[11] = merge(mdl1[11], 32'h1122_3344, 4'b0101);
    exp_q.push_back(mdl1[11]);
    run_op(1'b0, 1'b0, 6'd11, 32'h0, 4'hF, o);
    e = exp_q.pop_front();
    n_cmp++;
    if (!o.ok || o.rdata !== e) begin
      n_bad++; $display("FAIL partial_be: got %h want %h", o.rdata, e);
    end
  endtask

  task automatic test_simultaneous();
    exp_q.push_back(mdl1[2]);
    exp_q.push_back(init_val(7));
    @(posedge clk); #1;
    b1.mem_req = 1'b1; b1.mem_we = 1'b0; b1.mem_addr = 6'd2; b1.mem_be = 4'hF;
    b1.if_req = 1'b1; b1.if_addr = 6'd7;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      n_cmp += 4;
      if (b1.mem_done !== (c == 2)) begin
        n_bad++; $display("FAIL simul_mdone c%0d: got %b", c, b1.mem_done);
      end
      if (b1.if_done !== (c == 5)) begin
        n_bad++; $display("FAIL simul_idone c%0d: got %b", c, b1.if_done);
      end
      if (b1.if_stall !== (c < 5)) begin
        n_bad++; $display("FAIL simul_istall c%0d: got %b", c, b1.if_stall);
      end
      if (b1.ram_en !== (c == 1 || c == 4)) begin
        n_bad++; $display("FAIL simul_en c%0d: got %b", c, b1.ram_en);
      end
      if (c == 1 || c == 4) begin
        n_cmp++;
        if (b1.ram_addr !== (c == 1 ? 6'd2 : 6'd7)) begin
          n_bad++; $display("FAIL simul_addr c%0d: got %0d", c, b1.ram_addr);
        end
      end
      if ((b1.mem_done || b1.if_done) && exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        if ((b1.mem_done ? b1.mem_rdata : b1.if_rdata) !== e) begin
          n_bad++; $display("FAIL simul_data c%0d: got %h want %h", c,
                            b1.mem_done ? b1.mem_rdata : b1.if_rdata, e);
        end
      end
      @(posedge clk); #1;
      if (c == 0) b1.mem_addr = 6'd33;
      if (c == 2) b1.mem_req = 1'b0;
      if (c == 5) b1.if_req = 1'b0;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL simul_sb: %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_latency_sweep();
    exp_q.push_back(init_val(9));
    @(posedge clk); #1;
    b4.if_req = 1'b1; b4.if_addr = 6'd9;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      n_cmp += 2;
      if (b4.ram_en !== (c == 1)) begin
        n_bad++; $display("FAIL lat4_en c%0d: got %b", c, b4.ram_en);
      end
      if (b4.if_done !== (c == 5)) begin
        n_bad++; $display("FAIL lat4_done c%0d: got %b", c, b4.if_done);
      end
      if (b4.if_done && exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        if (b4.if_rdata !== e) begin
          n_bad++; $display("FAIL lat4_data: got %h want %h", b4.if_rdata, e);
        end
      end
      @(posedge clk); #1;
      if (c == 5) b4.if_req = 1'b0;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL lat4_sb: %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [5:0] a;
    logic [31:0] wd, e, prev_if, prev_mem;
    logic [3:0] be;
    for (int n = 0; n < 12; n++) begin
      a = 6'(16 + $urandom_range(0, 3));
      wd = $urandom;
      be = 4'($urandom_range(1, 15));
      prev_if = b1.if_rdata;
      prev_mem = b1.mem_rdata;
      if (n % 3 == 0) begin
        exp_q.push_back(mdl1[a]);
        run_op(1'b1, 1'b0, a, 32'h0, 4'h0, o);
      end else if (n % 3 == 1) begin
        mdl1[a] = merge(mdl1[a], wd, be);
        run_op(1'b0, 1'b1, a, wd, be, o);
      end else begin
        exp_q.push_back(mdl1[a]);
        run_op(1'b0, 1'b0, a, 32'h0, 4'hF, o);
      end
      n_cmp++;
      if (!o.ok || o.done_cyc != 2 || o.en_cnt != 1 || o.addr !== a) begin
        n_bad++; $display("FAIL b2b_timing n%0d: ok %0d done %0d en %0d a %0d want 1 2 1 %0d",
                          n, o.ok, o.done_cyc, o.en_cnt, o.addr, a);
      end
      n_cmp++;
      if (n % 3 == 0 ? (b1.mem_rdata !== prev_mem) : (b1.if_rdata !== prev_if)) begin
        n_bad++; $display("FAIL b2b_hold n%0d: if %h/%h mem %h/%h", n,
                          b1.if_rdata, prev_if, b1.mem_rdata, prev_mem);
      end
      if (n % 3 != 1) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (o.rdata !== e) begin
          n_bad++; $display("FAIL b2b_data n%0d: got %h want %h", n, o.rdata, e);
        end
      end else begin
        n_cmp++;
        if (o.we !== 1'b1 || o.be !== be || o.wdata !== wd) begin
          n_bad++; $display("FAIL b2b_store n%0d: we %b be %h d %h want 1 %h %h",
                            n, o.we, o.be, o.wdata, be, wd);
        end
      end
    end
  endtask

  task automatic test_guard();
    int g[$];
    int nd_busy;
    bit drop_if, drop_mem;
    nd_busy = 0;
    @(posedge clk); #1;
    b1.mem_req = 1'b1; b1.mem_we = 1'b0; b1.mem_addr = 6'd2; b1.mem_be = 4'hF;
    b1.if_req = 1'b1; b1.if_addr = 6'd1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (b1.ram_en && g.size() < 6) g.push_back(b1.ram_addr == 6'd1 ? 1 : 0);
      if (b1.if_done && b1.mem_req) nd_busy++;
      drop_if = b1.if_done;
      drop_mem = b1.mem_done && g.size() >= 6;
      @(posedge clk); #1;
      if (drop_if) b1.if_req = 1'b0;
      if (drop_mem) b1.mem_req = 1'b0;
      if (!b1.if_req && !b1.mem_req) break;
    end
    n_cmp++;
    if (b1.if_req || b1.mem_req || g.size() != 6) begin
      n_bad++; $display("FAIL guard_timeout: grants %0d reqs %b%b want 6 00",
                        g.size(), b1.if_req, b1.mem_req);
      rst = 1'b1; b1.if_req = 1'b0; b1.mem_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    for (int i = 0; i < g.size(); i++) begin
      int w;
`ifdef ARBITER_STARVATION_GUARD_EN
      w = (i == 4) ? 1 : 0;
`else
      w = 0;
`endif
      n_cmp++;
      if (g[i] != w) begin
        n_bad++; $display("FAIL guard_grant%0d: got %0d want %0d (1=IF)", i, g[i], w);
      end
    end
    n_cmp++;
`ifdef ARBITER_STARVATION_GUARD_EN
    if (nd_busy != 1) begin
      n_bad++; $display("FAIL guard_ifdone: got %0d want 1", nd_busy);
    end
`else
    if (nd_busy != 0) begin
      n_bad++; $display("FAIL guard_ifdone: got %0d want 0", nd_busy);
    end
`endif
  endtask

  initial begin
    b1.if_req = 1'b0; b1.if_addr = '0;
    b1.mem_req = 1'b0; b1.mem_we = 1'b0; b1.mem_addr = '0;
    b1.mem_wdata = '0; b1.mem_be = '0;
    b4.if_req = 1'b0; b4.if_addr = '0;
    b4.mem_req = 1'b0; b4.mem_we = 1'b0; b4.mem_addr = '0;
    b4.mem_wdata = '0; b4.mem_be = '0;
    test_reset();
    test_reset_mid_wait();
    test_single_fetch();
    test_store_load();
    test_simultaneous();
    test_latency_sweep();
    test_back_to_back();
    test_guard();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
